tc_pipe_mul: RTL and testbench

- Parametrised, pipelined integer multiplier for tracklet-calculator arithmetic; successor to the fixed 16ns x 17s -> 31 combinational DSP multiplier.
- Adds per-operand signedness, 1..4 register stages, arithmetic right-shift with optional round-half-up, optional saturation with overflow flag, a valid/ready handshake with backpressure, and a sideband tag carried alongside the data.
- Sits between HLS-generated datapath stages.
- Maps to one DSP48 cascade when STAGES>=2.

---
 rtl/tc_arith_pkg.sv | 33 +++
 rtl/tc_pipe_mul_stage.sv | 36 +++
 rtl/tc_pipe_mul.sv | 133 +++++++++++++
 tb/tb_tc_pipe_mul.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_arith_pkg.sv
// Shared arithmetic helpers for the tracklet-calculator multipliers:
// width/bias helpers and a signed saturating narrower.
package tc_arith_pkg;

  // Widest intermediate handled by sat_narrow; wider products are rejected at elaboration.
  localparam int NARROW_W = 128;

  // Full signed product width once each operand gains its extension bit.
  function automatic int full_w(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  // Half-up rounding bias added ahead of the arithmetic right shift.
  function automatic logic [NARROW_W-1:0] round_bias(input int shift, input bit round);
    logic [NARROW_W-1:0] bias;
    bias = '0;
    if (round && shift > 0) bias[shift-1] = 1'b1;
    return bias;
  endfunction

  // Clamp a signed value to a signed field of 'width' bits; returns {ovf, clamped}.
  function automatic logic [NARROW_W:0] sat_narrow(input logic signed [NARROW_W-1:0] value,
                                                   input int width);
    logic signed [NARROW_W-1:0] maxv;
    logic signed [NARROW_W-1:0] minv;
    minv = {NARROW_W{1'b1}} << (width - 1);
    maxv = ~minv;
    if (value > maxv)      return {1'b1, maxv};
    else if (value < minv) return {1'b1, minv};
    else                   return {1'b0, value};
  endfunction

endpackage

// File: rtl/tc_pipe_mul_stage.sv
// One pipeline slice of tc_pipe_mul: valid bit, sideband tag and data word,
// advanced together under a shared enable.
module tc_pipe_mul_stage
  import tc_arith_pkg::*;
#(
  parameter int DW    = 8,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [DW-1:0]    out_data
);

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // its upstream neighbour's pre-edge value, giving a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: data and tag are cleared as well as valid, so p/out_tag read 0
      // out of reset instead of whatever was in flight.
      out_tag   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_tag   <= in_tag;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/tc_pipe_mul.sv
// Pipelined signed/unsigned multiplier with round/shift, saturation and a
// valid/ready handshake; STAGES register slices, tag travels with the data.
module tc_pipe_mul
  import tc_arith_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 17,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 1,
  parameter int P_W      = 31,
  parameter int SHIFT    = 0,
  parameter int ROUND    = 0,
  parameter int SAT      = 0,
  parameter int STAGES   = 1,
  parameter int TAG_W    = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int F  = full_w(A_W, B_W);
  localparam int F1 = F + 1;
  localparam logic signed [F1-1:0] BIAS = F1'(round_bias(SHIFT, ROUND != 0));

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("tc_pipe_mul: STAGES must be 1..4");
  end
  if (SHIFT < 0 || SHIFT > A_W + B_W - 1) begin : g_bad_shift
    $error("tc_pipe_mul: SHIFT must be 0..A_W+B_W-1");
  end
  if (TAG_W < 1 || F1 > NARROW_W || P_W < 1 || P_W >= NARROW_W) begin : g_bad_width
    $error("tc_pipe_mul: unsupported width combination");
  end

  // Packed extended operands {a_ext, b_ext}, exactly F bits wide.
  function automatic logic [F-1:0] extend_ops(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
    logic xa;
    logic xb;
    xa = (A_SIGNED != 0) ? av[A_W-1] : 1'b0;
    xb = (B_SIGNED != 0) ? bv[B_W-1] : 1'b0;
    return {xa, av, xb, bv};
  endfunction

  // Extended operands are both signed, so the F-bit product is exact.
  function automatic logic signed [F-1:0] mul_ops(input logic [F-1:0] ops);
    logic signed [A_W:0] ae;
    logic signed [B_W:0] be;
    ae = ops[F-1 -: A_W+1];
    be = ops[B_W:0];
    return F'(ae) * F'(be);
  endfunction

  // Bias, shift and narrow; returns {ovf, p}.
  function automatic logic [P_W:0] narrow_result(input logic signed [F-1:0] prod);
    logic signed [F1-1:0]       sum;
    logic signed [F1-1:0]       r;
    logic signed [NARROW_W-1:0] wide;
    logic [NARROW_W:0]          nar;
    sum  = F1'(prod) + BIAS;
    r    = sum >>> SHIFT;
    wide = NARROW_W'(r);
    nar  = sat_narrow(wide, P_W);
    return {nar[NARROW_W], (SAT != 0) ? nar[P_W-1:0] : wide[P_W-1:0]};
  endfunction

  // Whole pipe advances together; a stalled full output freezes every slice.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar i = 1; i <= STAGES; i++) begin : g_st
    localparam int DW = (i == STAGES) ? P_W + 1 : F;
    logic             v_in;
    logic             v_out;
    logic [TAG_W-1:0] t_in;
    logic [TAG_W-1:0] t_out;
    logic [DW-1:0]    d_in;
    logic [DW-1:0]    d_out;

    if (i == 1) begin : g_src
      assign v_in = in_valid;
      assign t_in = in_tag;
      if (STAGES == 1) begin : g_all
        assign d_in = narrow_result(mul_ops(extend_ops(a, b)));
      end else begin : g_ops
        assign d_in = extend_ops(a, b);
      end
    end else begin : g_src
      assign v_in = g_st[i-1].v_out;
      assign t_in = g_st[i-1].t_out;
      if (i == 2 && STAGES == 2) begin : g_mul_fin
        assign d_in = narrow_result(mul_ops(g_st[i-1].d_out));
      end else if (i == 2) begin : g_mul
        assign d_in = mul_ops(g_st[i-1].d_out);
      end else if (i == STAGES) begin : g_fin
        assign d_in = narrow_result(g_st[i-1].d_out);
      end else begin : g_pass
        assign d_in = g_st[i-1].d_out;
      end
    end

    tc_pipe_mul_stage #(
      .DW    (DW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .en        (en),
      .in_valid  (v_in),
      .in_tag    (t_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_tag   (t_out),
      .out_data  (d_out)
    );
  end

  assign out_valid = g_st[STAGES].v_out;
  assign out_tag   = g_st[STAGES].t_out;
  assign p         = g_st[STAGES].d_out[P_W-1:0];
  assign ovf       = g_st[STAGES].d_out[P_W];

endmodule

// File: tb/tb_tc_pipe_mul.sv
// Self-checking bench for tc_pipe_mul: vector table across several parameter
// sets, randomized scoreboard on a stalled pipeline, and reset corner cases.
module tb_tc_pipe_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic straight from the arithmetic rules.
  function automatic void ref_mul(input longint av, input longint bv, input int shift,
                                  input int round, input int sat, input int pw,
                                  output longint pr, output bit ovr);
    longint r, maxv, minv;
    r = av * bv;
    if (round != 0 && shift > 0) r = r + (longint'(1) <<< (shift - 1));
    r = r >>> shift;
    maxv = (longint'(1) <<< (pw - 1)) - 1;
    minv = -maxv - 1;
    ovr = (r > maxv) || (r < minv);
    if (sat != 0 && r > maxv) r = maxv;
    else if (sat != 0 && r < minv) r = minv;
    pr = r & ((longint'(1) <<< pw) - 1);
  endfunction

  logic        rst_n, rst_r;
  logic        v1, rv;
  logic [15:0] a16;
  logic [16:0] b17;
  logic [7:0]  tag8;
  logic [3:0]  a4, b4;

  logic        def_ir, def_ov, def_ovf;  logic [30:0] def_p; logic [7:0] def_tag;
  logic        sat_ir, sat_ov, sat_ovf;  logic [7:0]  sat_p; logic [7:0] sat_tag;
  logic        wr_ir, wr_ov, wr_ovf;     logic [7:0]  wr_p;  logic [7:0] wr_tag;
  logic        s4_ir, s4_ov, s4_ovf;     logic [30:0] s4_p;  logic [7:0] s4_tag;
  logic        u4_ir, u4_ov, u4_ovf;     logic [30:0] u4_p;  logic [7:0] u4_tag;
  logic        rs_ir, rs_ov, rs_ovf;     logic [30:0] rs_p;  logic [7:0] rs_tag;

  logic        pv, prdy, p_in_ready, p_ov, p_ovf;
  logic [15:0] pa;
  logic [16:0] pb;
  logic [7:0]  ptag, p_tag;
  logic [19:0] p_p;

  tc_pipe_mul u_def (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v1), .in_ready(def_ir),
    .a(a16), .b(b17), .in_tag(tag8), .out_valid(def_ov), .out_ready(1'b1),
    .p(def_p), .ovf(def_ovf), .out_tag(def_tag));

  tc_pipe_mul #(.P_W(8), .SAT(1)) u_sat (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v1),
    .in_ready(sat_ir), .a(a16), .b(b17), .in_tag(tag8), .out_valid(sat_ov),
    .out_ready(1'b1), .p(sat_p), .ovf(sat_ovf), .out_tag(sat_tag));

  tc_pipe_mul #(.P_W(8), .SAT(0)) u_wrap (.ap_clk(clk), .ap_rst_n(rst_n), .in_valid(v1),
    .in_ready(wr_ir), .a(a16), .b(b17), .in_tag(tag8), .out_valid(wr_ov),
    .out_ready(1'b1), .p(wr_p), .ovf(wr_ovf), .out_tag(wr_tag));

  tc_pipe_mul #(.A_W(4), .B_W(4), .A_SIGNED(1), .B_SIGNED(1)) u_s4 (.ap_clk(clk),
    .ap_rst_n(rst_n), .in_valid(v1), .in_ready(s4_ir), .a(a4), .b(b4), .in_tag(tag8),
    .out_valid(s4_ov), .out_ready(1'b1), .p(s4_p), .ovf(s4_ovf), .out_tag(s4_tag));

  tc_pipe_mul #(.A_W(4), .B_W(4), .A_SIGNED(0), .B_SIGNED(1)) u_u4 (.ap_clk(clk),
    .ap_rst_n(rst_n), .in_valid(v1), .in_ready(u4_ir), .a(a4), .b(b4), .in_tag(tag8),
    .out_valid(u4_ov), .out_ready(1'b1), .p(u4_p), .ovf(u4_ovf), .out_tag(u4_tag));

  tc_pipe_mul #(.STAGES(4)) u_rst (.ap_clk(clk), .ap_rst_n(rst_r), .in_valid(rv),
    .in_ready(rs_ir), .a(a16), .b(b17), .in_tag(tag8), .out_valid(rs_ov),
    .out_ready(1'b1), .p(rs_p), .ovf(rs_ovf), .out_tag(rs_tag));

  tc_pipe_mul #(.P_W(20), .SHIFT(4), .ROUND(1), .SAT(1), .STAGES(3)) u_pipe (.ap_clk(clk),
    .ap_rst_n(rst_n), .in_valid(pv), .in_ready(p_in_ready), .a(pa), .b(pb), .in_tag(ptag),
    .out_valid(p_ov), .out_ready(prdy), .p(p_p), .ovf(p_ovf), .out_tag(p_tag));

  typedef struct {
    logic [15:0] a;
    logic [16:0] b;
    logic [30:0] p_def;
    logic        ovf_def;
    logic [7:0]  p_sat;
    logic        ovf_sat;
    logic [7:0]  p_wrap;
    logic        ovf_wrap;
  } vec_t;

  typedef struct {
    logic [19:0] p;
    logic        ovf;
    logic [7:0]  tag;
  } exp_t;

  vec_t        tbl[10];
  exp_t        sb[$];
  logic [19:0] got_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  logic        acc, rdy, seen;
  int          tag_next, stall_left;
  longint      mp;
  bit          mo;

  // One handshake cycle on u_pipe; the caller has already waited for the negedge.
  task automatic pipe_step(input logic v, input logic [15:0] aa, input logic [16:0] bb,
                           input logic [7:0] tg, input logic r, output logic accepted);
    exp_t   e;
    longint xp;
    bit     xo;
    pv = v; pa = aa; pb = bb; ptag = tg; prdy = r;
    #1;
    if (p_ov && r) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL pipe_spurious: got tag %0h with no result outstanding", p_tag);
      end else begin
        e = sb.pop_front();
        check("pipe_p", p_p, e.p);
        check("pipe_ovf", p_ovf, e.ovf);
        check("pipe_tag", p_tag, e.tag);
        got_q.push_back(p_p);
        cyc_q.push_back(cyc);
      end
    end
    accepted = v && p_in_ready;
    if (accepted) begin
      ref_mul(longint'(aa), longint'($signed(bb)), 4, 1, 1, 20, xp, xo);
      e.p = xp[19:0]; e.ovf = xo; e.tag = tg;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic pipe_drain();
    logic dummy;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      pipe_step(1'b0, 16'd0, 17'd0, 8'd0, 1'b1, dummy);
    end
    check("pipe_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    tbl[0] = '{16'd100,  17'd2,       31'd200,         1'b0, 8'h7F, 1'b1, 8'hC8, 1'b1};
    tbl[1] = '{16'd100,  17'h1FFFE,   31'h7FFFFF38,    1'b0, 8'h80, 1'b1, 8'h38, 1'b1};
    tbl[2] = '{16'd10,   17'h1FFFD,   31'h7FFFFFE2,    1'b0, 8'hE2, 1'b0, 8'hE2, 1'b0};
    tbl[3] = '{16'd0,    17'd0,       31'd0,           1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{16'd127,  17'd1,       31'd127,         1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0};
    tbl[5] = '{16'd128,  17'd1,       31'd128,         1'b0, 8'h7F, 1'b1, 8'h80, 1'b1};
    tbl[6] = '{16'd128,  17'h1FFFF,   31'h7FFFFF80,    1'b0, 8'h80, 1'b0, 8'h80, 1'b0};
    tbl[7] = '{16'd129,  17'h1FFFF,   31'h7FFFFF7F,    1'b0, 8'h80, 1'b1, 8'h7F, 1'b1};
    tbl[8] = '{16'd1000, 17'h1FFFD,   31'h7FFFF448,    1'b0, 8'h80, 1'b1, 8'h48, 1'b1};
    tbl[9] = '{16'hFFFF, 17'h10000,   31'h00010000,    1'b1, 8'h80, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0; rst_r = 1'b0;
    v1 = 1'b0; rv = 1'b0; a16 = '0; b17 = '0; tag8 = '0; a4 = '0; b4 = '0;
    pv = 1'b0; pa = '0; pb = '0; ptag = '0; prdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_def_valid", def_ov, 1'b0);
    check("rst_def_p", def_p, 31'd0);
    check("rst_def_ovf", def_ovf, 1'b0);
    check("rst_def_tag", def_tag, 8'd0);
    check("rst_pipe_valid", p_ov, 1'b0);
    check("rst_pipe_p", p_p, 20'd0);
    rst_n = 1'b1; rst_r = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", def_ir, 1'b1);
    check("rst_pipe_in_ready", p_in_ready, 1'b1);

    // Table: defaults, P_W=8 saturating and wrapping, one edge of latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v1 = 1'b1; a16 = tbl[i].a; b17 = tbl[i].b; tag8 = 8'(i + 1);
      @(posedge clk); #1;
      check("def_valid", def_ov, 1'b1);
      check("def_p", def_p, tbl[i].p_def);
      check("def_ovf", def_ovf, tbl[i].ovf_def);
      check("def_tag", def_tag, 8'(i + 1));
      check("sat_p", sat_p, tbl[i].p_sat);
      check("sat_ovf", sat_ovf, tbl[i].ovf_sat);
      check("wrap_p", wr_p, tbl[i].p_wrap);
      check("wrap_ovf", wr_ovf, tbl[i].ovf_wrap);
    end
    @(negedge clk); v1 = 1'b0;
    @(posedge clk); #1;
    check("def_bubble", def_ov, 1'b0);

    // Operand signedness on 4-bit operands
    @(negedge clk); v1 = 1'b1; a4 = 4'h8; b4 = 4'h8;
    @(posedge clk); #1;
    check("s4_neg8_neg8", s4_p, 31'd64);
    check("u4_8_neg8", u4_p, 31'h7FFFFFC0);
    @(negedge clk); a4 = 4'hF; b4 = 4'hF;
    @(posedge clk); #1;
    check("s4_neg1_neg1", s4_p, 31'd1);
    check("u4_15_neg1", u4_p, 31'h7FFFFFF1);

    // Randomized defaults against the reference model
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b17 = 17'($urandom); tag8 = 8'($urandom);
      @(posedge clk); #1;
      ref_mul(longint'(a16), longint'($signed(b17)), 0, 0, 0, 31, mp, mo);
      check("rand_def_p", def_p, 64'(mp));
      check("rand_def_ovf", def_ovf, mo);
      check("rand_def_tag", def_tag, tag8);
    end
    @(negedge clk); v1 = 1'b0;

    // Round-half-up sequence, back-to-back with no bubbles
    got_q.delete(); cyc_q.delete();
    @(negedge clk); pipe_step(1'b1, 16'd25, 17'd1, 8'd1, 1'b1, acc);
    @(negedge clk); pipe_step(1'b1, 16'd24, 17'd1, 8'd2, 1'b1, acc);
    @(negedge clk); pipe_step(1'b1, 16'd23, 17'd1, 8'd3, 1'b1, acc);
    @(negedge clk); pipe_step(1'b1, 16'd24, 17'h1FFFF, 8'd4, 1'b1, acc);
    pipe_drain();
    check("round_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check("round_25", got_q[0], 20'd2);
      check("round_24", got_q[1], 20'd2);
      check("round_23", got_q[2], 20'd1);
      check("round_neg24", got_q[3], 20'hFFFFF);
      check("round_no_bubble", 64'(cyc_q[3] - cyc_q[0]), 64'd3);
    end

    // Backpressure: tags 1..6, out_ready low 5 cycles after the first result
    got_q.delete();
    tag_next = 1; seen = 1'b0; stall_left = 5;
    for (int c = 0; c < 60 && tag_next <= 6; c++) begin
      @(negedge clk);
      if (p_ov) seen = 1'b1;
      rdy = !(seen && stall_left > 0);
      pipe_step(1'b1, 16'(100 + tag_next * 7), 17'(tag_next * 3), 8'(tag_next), rdy, acc);
      if (!rdy) begin
        check("stall_in_ready", p_in_ready, 1'b0);
        check("stall_valid", p_ov, 1'b1);
        check("stall_tag", p_tag, 8'd1);
        if (sb.size() > 0) check("stall_p", p_p, sb[0].p);
        stall_left--;
      end
      if (acc) tag_next++;
    end
    pipe_drain();
    check("stall_done", 64'(stall_left), 64'd0);
    check("stall_count", 64'(got_q.size()), 64'd6);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [15:0] ra;
      logic [16:0] rb;
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        ra = 16'($urandom_range(0, 4095));
        rb = 17'($signed(12'($urandom)));
      end else begin
        ra = 16'($urandom);
        rb = 17'($urandom);
      end
      pipe_step($urandom_range(0, 3) != 0, ra, rb, 8'($urandom),
                $urandom_range(0, 3) != 0, acc);
    end
    pipe_drain();

    // Asynchronous reset mid-cycle with items in flight (STAGES=4)
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rv = 1'b1; a16 = 16'(1230 + k); b17 = 17'h1FFB3; tag8 = 8'(k);
    end
    @(negedge clk); rv = 1'b0;
    ref_mul(longint'(16'd1231), -longint'(77), 0, 0, 0, 31, mp, mo);
    check("pre_rst_valid", rs_ov, 1'b1);
    check("pre_rst_p", rs_p, 64'(mp));
    check("pre_rst_tag", rs_tag, 8'd1);
    #2 rst_r = 1'b0;
    #1;
    check("async_rst_valid", rs_ov, 1'b0);
    check("async_rst_p", rs_p, 31'd0);
    check("async_rst_ovf", rs_ovf, 1'b0);
    check("async_rst_tag", rs_tag, 8'd0);
    repeat (2) @(negedge clk);
    rst_r = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_empty", rs_ov, 1'b0);
    end
    @(negedge clk);
    rv = 1'b1; a16 = 16'd321; b17 = 17'd45; tag8 = 8'd9;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      rv = 1'b0;
      check("restart_valid", rs_ov, 1'(e == 4));
    end
    check("restart_p", rs_p, 31'd14445);
    check("restart_tag", rs_tag, 8'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
